// File: rtl/pe_slave_kmp.sv
// pe_slave_kmp -- single-job substring search engine.
//
// A job is a string of MAX_STRING characters, a pattern of up to
// MAX_PATTERN characters, and an inclusive search window
// [start_idx, end_idx]. All job inputs are captured when the job is
// accepted. The engine reports:
//   - the number of (overlapping) occurrences of the pattern that lie
//     wholly inside the window, and
//   - the lowest start index among those occurrences.
//
// Two search modes:
//   - KMP mode (wildcard_en=0): a failure table is built in PRE, one
//     step per cycle, and is then used by the COM search.
//   - Wildcard mode (wildcard_en=1): pattern character '.' matches any
//     character. No failure table is used; a mismatch restarts the
//     search at the next window start position.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   str_input    string; char i = bits [i*BYTE +: BYTE]
//   pat_input    pattern; same packing as str_input
//   pat_len      number of valid pattern characters
//   start_idx    first string index of the search window
//   end_idx      last string index of the search window
//   wildcard_en  enables '.' as a match-any pattern character
//   input_valid  job handshake, from requester
//   input_ready  job handshake, to requester (high only in IDLE)
//   output_valid result handshake (high only in DONE)
//   output_ready result handshake, from consumer
//   match        at least one occurrence found
//   match_idx    lowest occurrence start (0 when none)
//   match_cnt    occurrence count, saturating
//   err          job rejected: bad pattern length or window
module pe_slave_kmp #(
    parameter  int BYTE        = 8,
    parameter  int MAX_STRING  = 32,
    parameter  int MAX_PATTERN = 8,
    localparam int STR_ADD     = $clog2(MAX_STRING),
    localparam int PAT_ADD     = $clog2(MAX_PATTERN) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MAX_STRING*BYTE-1:0]  str_input,
    input  logic [MAX_PATTERN*BYTE-1:0] pat_input,
    input  logic [PAT_ADD-1:0]          pat_len,
    input  logic [STR_ADD-1:0]          start_idx,
    input  logic [STR_ADD-1:0]          end_idx,
    input  logic                        wildcard_en,
    input  logic                        input_valid,
    output logic                        input_ready,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic                        match,
    output logic [STR_ADD-1:0]          match_idx,
    output logic [STR_ADD:0]            match_cnt,
    output logic                        err
);

    localparam int                CNT_W     = STR_ADD + 1;
    localparam int                PIX       = (MAX_PATTERN > 1) ? $clog2(MAX_PATTERN) : 1;
    localparam logic [BYTE-1:0]   WILD_CHAR = BYTE'(8'h2E);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        PRE  = 4'b0010,
        COM  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t               state_r;
    state_t               state_s;

    // Latched job.
    logic [BYTE-1:0]      str_r  [MAX_STRING];
    logic [BYTE-1:0]      pat_r  [MAX_PATTERN];
    logic [PAT_ADD-1:0]   fail_r [MAX_PATTERN];
    logic [PAT_ADD-1:0]   pat_len_r;
    logic [STR_ADD-1:0]   end_r;
    logic                 wild_r;

    // PRE: i_r is the table position being filled; k_r is the current
    // border length.
    logic [PAT_ADD-1:0]   i_r;
    logic [PAT_ADD-1:0]   k_r;

    // COM: s_r is one bit wider than a string index so it can step past
    // end_idx = MAX_STRING-1.
    logic [CNT_W-1:0]     s_r;
    logic [PAT_ADD-1:0]   j_r;
    logic [CNT_W-1:0]     hit_cnt_r;
    logic [STR_ADD-1:0]   first_idx_r;

    // Registered results.
    logic                 match_r;
    logic [STR_ADD-1:0]   match_idx_r;
    logic [CNT_W-1:0]     match_cnt_r;
    logic                 err_r;

    // Combinational helpers.
    logic [CNT_W-1:0]     span_s;
    logic                 job_err_s;
    logic [BYTE-1:0]      pre_ch_i_s;
    logic [BYTE-1:0]      pre_ch_k_s;
    logic [PIX-1:0]       k_m1_s;
    logic [PIX-1:0]       j_m1_s;
    logic [PIX-1:0]       plm1_s;
    logic [BYTE-1:0]      str_ch_s;
    logic [BYTE-1:0]      pat_ch_s;
    logic                 ch_eq_s;
    logic [CNT_W-1:0]     rem_s;
    logic [PAT_ADD-1:0]   need_s;
    logic                 com_done_s;
    logic                 pre_done_s;
    logic [STR_ADD-1:0]   pos_s;
    logic [CNT_W-1:0]     restart_s;

    // Handshake flags are single bits of the one-hot state register.
    assign input_ready  = state_r[0];
    assign output_valid = state_r[3];
    assign match        = match_r;
    assign match_idx    = match_idx_r;
    assign match_cnt    = match_cnt_r;
    assign err          = err_r;

    // Job validation, table-build and compare-step decode.
    always_comb begin
        span_s    = {1'b0, end_idx} - {1'b0, start_idx} + CNT_W'(1'b1);
        job_err_s = 1'b0;
        if ((pat_len == {PAT_ADD{1'b0}}) || (pat_len > PAT_ADD'(MAX_PATTERN))) begin
            job_err_s = 1'b1;
        end else if (end_idx < start_idx) begin
            job_err_s = 1'b1;
        end else if (span_s < CNT_W'(pat_len)) begin
            job_err_s = 1'b1;
        end else begin
            job_err_s = 1'b0;
        end

        pre_ch_i_s = pat_r[i_r[PIX-1:0]];
        pre_ch_k_s = pat_r[k_r[PIX-1:0]];
        k_m1_s     = k_r[PIX-1:0] - PIX'(1'b1);
        j_m1_s     = j_r[PIX-1:0] - PIX'(1'b1);
        // pat_len is 1..MAX_PATTERN here, so the low bits minus one wrap
        // correctly to pat_len-1.
        plm1_s     = pat_len_r[PIX-1:0] - PIX'(1'b1);
        pre_done_s = wild_r || (i_r >= pat_len_r);

        str_ch_s   = str_r[s_r[STR_ADD-1:0]];
        pat_ch_s   = pat_r[j_r[PIX-1:0]];
        ch_eq_s    = (str_ch_s == pat_ch_s) || (wild_r && (pat_ch_s == WILD_CHAR));

        // Stop once s is past the window, or too few characters remain to
        // finish the partial match already in progress.
        rem_s      = {1'b0, end_r} - s_r + CNT_W'(1'b1);
        need_s     = pat_len_r - j_r;
        com_done_s = (s_r > {1'b0, end_r}) || (rem_s < CNT_W'(need_s));

        pos_s      = s_r[STR_ADD-1:0] - STR_ADD'(pat_len_r) + STR_ADD'(1'b1);
        restart_s  = s_r - CNT_W'(j_r) + CNT_W'(1'b1);
    end

    // Next-state logic for the one-hot job FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (input_valid) begin
                    state_s = job_err_s ? DONE : PRE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRE: begin
                if (pre_done_s) begin
                    state_s = COM;
                end else begin
                    state_s = PRE;
                end
            end
            COM: begin
                if (com_done_s) begin
                    state_s = DONE;
                end else begin
                    state_s = COM;
                end
            end
            DONE: begin
                if (output_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job capture, failure-table build, search datapath and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < MAX_STRING; n++) begin
                str_r[n] <= {BYTE{1'b0}};
            end
            for (int n = 0; n < MAX_PATTERN; n++) begin
                pat_r[n]  <= {BYTE{1'b0}};
                fail_r[n] <= {PAT_ADD{1'b0}};
            end
            pat_len_r   <= {PAT_ADD{1'b0}};
            end_r       <= {STR_ADD{1'b0}};
            wild_r      <= 1'b0;
            i_r         <= {PAT_ADD{1'b0}};
            k_r         <= {PAT_ADD{1'b0}};
            s_r         <= {CNT_W{1'b0}};
            j_r         <= {PAT_ADD{1'b0}};
            hit_cnt_r   <= {CNT_W{1'b0}};
            first_idx_r <= {STR_ADD{1'b0}};
            match_r     <= 1'b0;
            match_idx_r <= {STR_ADD{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (input_valid) begin
                        for (int n = 0; n < MAX_STRING; n++) begin
                            str_r[n] <= str_input[n*BYTE +: BYTE];
                        end
                        for (int n = 0; n < MAX_PATTERN; n++) begin
                            pat_r[n]  <= pat_input[n*BYTE +: BYTE];
                            fail_r[n] <= {PAT_ADD{1'b0}};
                        end
                        pat_len_r   <= pat_len;
                        end_r       <= end_idx;
                        wild_r      <= wildcard_en;
                        i_r         <= PAT_ADD'(1'b1);
                        k_r         <= {PAT_ADD{1'b0}};
                        s_r         <= {1'b0, start_idx};
                        j_r         <= {PAT_ADD{1'b0}};
                        hit_cnt_r   <= {CNT_W{1'b0}};
                        first_idx_r <= {STR_ADD{1'b0}};
                        if (job_err_s) begin
                            match_r     <= 1'b0;
                            match_idx_r <= {STR_ADD{1'b0}};
                            match_cnt_r <= {CNT_W{1'b0}};
                            err_r       <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (!pre_done_s) begin
                        if (pre_ch_i_s == pre_ch_k_s) begin
                            fail_r[i_r[PIX-1:0]] <= k_r + PAT_ADD'(1'b1);
                            k_r <= k_r + PAT_ADD'(1'b1);
                            i_r <= i_r + PAT_ADD'(1'b1);
                        end else if (k_r != {PAT_ADD{1'b0}}) begin
                            k_r <= fail_r[k_m1_s];
                        end else begin
                            fail_r[i_r[PIX-1:0]] <= {PAT_ADD{1'b0}};
                            i_r <= i_r + PAT_ADD'(1'b1);
                        end
                    end
                end
                COM: begin
                    if (com_done_s) begin
                        match_r     <= (hit_cnt_r != {CNT_W{1'b0}});
                        match_idx_r <= first_idx_r;
                        match_cnt_r <= hit_cnt_r;
                        err_r       <= 1'b0;
                    end else if (!wild_r && (j_r == pat_len_r)) begin
                        // Step after a full match: fall back along the table
                        // without consuming a character.
                        j_r <= fail_r[plm1_s];
                    end else if (ch_eq_s) begin
                        if (j_r == (pat_len_r - PAT_ADD'(1'b1))) begin
                            if (hit_cnt_r == {CNT_W{1'b0}}) begin
                                first_idx_r <= pos_s;
                            end
                            if (hit_cnt_r != CNT_MAX) begin
                                hit_cnt_r <= hit_cnt_r + CNT_W'(1'b1);
                            end
                        end
                        if (wild_r && (j_r == (pat_len_r - PAT_ADD'(1'b1)))) begin
                            s_r <= restart_s;
                            j_r <= {PAT_ADD{1'b0}};
                        end else begin
                            s_r <= s_r + CNT_W'(1'b1);
                            j_r <= j_r + PAT_ADD'(1'b1);
                        end
                    end else if (wild_r) begin
                        s_r <= restart_s;
                        j_r <= {PAT_ADD{1'b0}};
                    end else if (j_r != {PAT_ADD{1'b0}}) begin
                        j_r <= fail_r[j_m1_s];
                    end else begin
                        s_r <= s_r + CNT_W'(1'b1);
                    end
                end
                DONE: begin
                    match_r <= match_r;
                end
                default: begin
                    match_r <= match_r;
                end
            endcase
        end
    end

endmodule
